// File: rtl/mem_client_arbiter_pkg.sv
// rtl/mem_client_arbiter_pkg.sv - shared command encodings and width helpers
package mem_client_arbiter_pkg;

    localparam int TX_CMD_BITS = 4;

    typedef enum logic [TX_CMD_BITS-1:0] {
        TX_HEADER_IDLE     = 4'h0,
        TX_HEADER_READ_16  = 4'h1,
        TX_HEADER_WRITE_16 = 4'h2
    } tx_header_e;

    // Client-ID width; never zero so a 1-client build still has a legal vector.
    function automatic int mem_id_w(input int num_clients);
        return (num_clients > 2) ? $clog2(num_clients) : 1;
    endfunction

endpackage

// File: rtl/mem_client_arbiter_fifo.sv
// rtl/mem_client_arbiter_fifo.sv - reply-owner FIFO, any depth, push allowed on a full pop
module mem_client_arbiter_fifo
    import mem_client_arbiter_pkg::*;
#(
    parameter int BITS   = 2,
    parameter int DEPTH  = 7,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [BITS-1:0]  din,
    input  logic             pop,
    output logic [BITS-1:0]  dout,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    logic [BITS-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mem_client_arbiter.sv
// rtl/mem_client_arbiter.sv - N-client TX ownership arbiter and RX reply router
module mem_client_arbiter
    import mem_client_arbiter_pkg::*;
#(
    parameter int NUM_CLIENTS     = 2,
    parameter int IO_BITS         = 2,
    parameter int CMD_BITS        = TX_CMD_BITS,
    parameter int MAX_OUTSTANDING = 7,
    parameter int DEFAULT_OWNER   = 0,
    parameter int ROUND_ROBIN     = 0,
    localparam int ID_W           = mem_id_w(NUM_CLIENTS),
    localparam int OCC_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CLIENTS-1:0]          cl_want,
    input  logic [NUM_CLIENTS-1:0]          cl_cmd_valid,
    input  logic [NUM_CLIENTS*CMD_BITS-1:0] cl_cmd,
    input  logic [NUM_CLIENTS*IO_BITS-1:0]  cl_data,
    input  logic [NUM_CLIENTS-1:0]          cl_reply_wanted,
    input  logic [NUM_CLIENTS-1:0]          cl_reserve,
    output logic                            tx_command_valid,
    output logic [CMD_BITS-1:0]             tx_command,
    output logic [IO_BITS-1:0]              tx_data,
    input  logic                            tx_command_started,
    input  logic                            tx_active,
    input  logic                            tx_data_next,
    input  logic                            tx_done,
    input  logic                            rx_started,
    input  logic                            rx_active,
    input  logic                            rx_sbs_valid,
    input  logic                            rx_data_valid,
    input  logic                            rx_done,
    output logic [NUM_CLIENTS-1:0]          cl_tx_started,
    output logic [NUM_CLIENTS-1:0]          cl_tx_active,
    output logic [NUM_CLIENTS-1:0]          cl_tx_data_next,
    output logic [NUM_CLIENTS-1:0]          cl_tx_done,
    output logic [NUM_CLIENTS-1:0]          cl_rx_started,
    output logic [NUM_CLIENTS-1:0]          cl_rx_active,
    output logic [NUM_CLIENTS-1:0]          cl_rx_sbs_valid,
    output logic [NUM_CLIENTS-1:0]          cl_rx_data_valid,
    output logic [NUM_CLIENTS-1:0]          cl_rx_done,
    output logic [ID_W-1:0]                 owner_id,
    output logic [OCC_W-1:0]                outstanding,
    output logic                            fifo_full,
    output logic                            rx_orphan
);

    localparam int ENTRY_W = 1 + ID_W;

    logic [ID_W-1:0]        owner_q;
    logic [ID_W-1:0]        rr_ptr;
    logic [ID_W-1:0]        pick;
    logic [NUM_CLIENTS-1:0] req;
    logic [NUM_CLIENTS-1:0] owner_onehot;
    logic [NUM_CLIENTS-1:0] reply_onehot;
    logic [ENTRY_W-1:0]     push_entry;
    logic [ENTRY_W-1:0]     head_entry;
    logic [ID_W-1:0]        head_id;
    logic                   head_v;
    logic                   fifo_push;
    logic                   fifo_empty;
    logic                   rx_any;

    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_CLIENTS) sum = sum - NUM_CLIENTS;
        return ID_W'(sum);
    endfunction

    assign req = cl_want | cl_cmd_valid;

    always_comb begin
        pick = ID_W'(DEFAULT_OWNER);
        if (cl_reserve[owner_q]) begin
            pick = owner_q;
        end else if (ROUND_ROBIN != 0) begin
            // Scan downward so the nearest requester at or after rr_ptr is the last to land.
            for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
                if (req[rr_index(rr_ptr, k)]) pick = rr_index(rr_ptr, k);
            end
        end else begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if (req[ID_W'(i)]) pick = ID_W'(i);
            end
        end
    end

    assign owner_id         = tx_active ? owner_q : pick;
    assign tx_command       = cl_cmd[int'(owner_id)*CMD_BITS +: CMD_BITS];
    assign tx_data          = cl_data[int'(owner_id)*IO_BITS +: IO_BITS];
    assign tx_command_valid = !reset && cl_cmd_valid[owner_id] && !fifo_full;

    assign owner_onehot    = reset ? '0 : (NUM_CLIENTS'(1) << owner_id);
    assign cl_tx_started   = {NUM_CLIENTS{tx_command_started}} & owner_onehot;
    assign cl_tx_active    = {NUM_CLIENTS{tx_active}}          & owner_onehot;
    assign cl_tx_data_next = {NUM_CLIENTS{tx_data_next}}       & owner_onehot;
    assign cl_tx_done      = {NUM_CLIENTS{tx_done}}            & owner_onehot;

    // Only reads produce a reply; writes leave the FIFO untouched.
    assign fifo_push  = tx_command_started && (tx_command == CMD_BITS'(TX_HEADER_READ_16));
    assign push_entry = {cl_reply_wanted[owner_id], owner_id};
    assign {head_v, head_id} = head_entry;
    assign rx_any = rx_started | rx_active | rx_sbs_valid | rx_data_valid | rx_done;

    assign reply_onehot     = (!reset && !fifo_empty && head_v) ? (NUM_CLIENTS'(1) << head_id) : '0;
    assign cl_rx_started    = {NUM_CLIENTS{rx_started}}    & reply_onehot;
    assign cl_rx_active     = {NUM_CLIENTS{rx_active}}     & reply_onehot;
    assign cl_rx_sbs_valid  = {NUM_CLIENTS{rx_sbs_valid}}  & reply_onehot;
    assign cl_rx_data_valid = {NUM_CLIENTS{rx_data_valid}} & reply_onehot;
    assign cl_rx_done       = {NUM_CLIENTS{rx_done}}       & reply_onehot;

    mem_client_arbiter_fifo #(
        .BITS  (ENTRY_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_reply_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (push_entry),
        .pop   (rx_done),
        .dout  (head_entry),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (outstanding)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q   <= ID_W'(DEFAULT_OWNER);
            rr_ptr    <= '0;
            rx_orphan <= 1'b0;
        end else begin
            if (!tx_active)              owner_q   <= pick;
            if (tx_command_started)      rr_ptr    <= rr_index(owner_id, 1);
            if (rx_any && fifo_empty)    rx_orphan <= 1'b1;
        end
    end

endmodule
